// File: rtl/small_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : small_result_packer
// Description : Packs 4*DW-bit result words from a multiplier node into
//               256-bit output lines (K = 256/(4*DW) words per line, slot 0 in
//               the least significant bits). Completed lines are queued in a
//               FIFO_DEPTH-entry line FIFO. The head line is presented on
//               registered outputs. Each line is tagged "last" when it closes
//               a node of (num_of_line_per_node_minusone + 1) lines.
//
//   Ports
//     clk                            : single clock, rising edge
//     rst                            : synchronous reset, active low
//     in_data / in_vld / in_ready    : result word input handshake
//     num_of_line_per_node_minusone  : lines per node minus one, latched at
//                                      node start
//     max_exponent / max_exponent_vld: node exponent and its qualifying strobe
//     out_data / out_vld / out_ready : packed line output handshake
//     out_last                       : head line is the final line of a node
//     out_max_exponent               : exponent tag of the head line
//
//   Build option
//     RESULT_PACKER_MAXEXP_EN : when defined, exponent tagging is built.
//                               When undefined, out_max_exponent is
//                               constant 0 and the exponent inputs are unused.
//
// Revision    : 1.0 - initial release
// ============================================================================
module small_result_packer #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4*DW-1:0] in_data,
    input  logic            in_vld,
    output logic            in_ready,
    input  logic [10:0]     num_of_line_per_node_minusone,
    input  logic [7:0]      max_exponent,
    input  logic            max_exponent_vld,
    output logic [255:0]    out_data,
    output logic            out_vld,
    input  logic            out_ready,
    output logic            out_last,
    output logic [7:0]      out_max_exponent
);

    localparam int c_word_w = 4 * DW;
    localparam int c_k      = 256 / c_word_w;
    localparam int c_slot_w = (c_k > 1) ? $clog2(c_k) : 1;
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);

    localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(c_k - 1);
    localparam logic [c_ptr_w:0]    c_full_cnt  = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // Line assembly state
    // ------------------------------------------------------------------
    logic [c_slot_w-1:0] r_slot_cnt;
    logic [255:0]        r_line;
    logic [10:0]         r_line_cnt;
    logic [10:0]         r_lines_m1;

    // ------------------------------------------------------------------
    // Line FIFO state
    // ------------------------------------------------------------------
    logic [255:0]       r_data_mem [FIFO_DEPTH];
    logic               r_last_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;

    logic [255:0]       r_out_data;
    logic               r_out_vld;
    logic               r_out_last;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_full;
    logic               w_slot_last;
    logic               w_in_hs;
    logic               w_push;
    logic               w_pop;
    logic               w_latch;
    logic [10:0]        w_lines_m1;
    logic               w_push_last;
    logic [255:0]       w_line_next;
    logic [c_ptr_w-1:0] w_rd_nxt;
    logic [c_ptr_w:0]   w_cnt_nxt;
    logic               w_head_bypass;

    assign w_full      = (r_count == c_full_cnt);
    assign w_slot_last = (r_slot_cnt == c_last_slot);

    // Stall only when the incoming word would complete a line that has no
    // FIFO room; out_ready deliberately does not participate.
    assign in_ready    = !w_slot_last || !w_full;

    assign w_in_hs     = in_vld && in_ready;
    assign w_push      = w_in_hs && w_slot_last;
    assign w_pop       = r_out_vld && out_ready;

    // The line count is captured on the first word of a node. When K == 1
    // that same word also completes the line, so the fresh value is used.
    assign w_latch     = w_in_hs && (r_line_cnt == 11'd0) && (r_slot_cnt == '0);
    assign w_lines_m1  = w_latch ? num_of_line_per_node_minusone : r_lines_m1;
    assign w_push_last = (r_line_cnt == w_lines_m1);

    // Current line with the incoming word merged into its slot; this is
    // also the value pushed when the word lands in the final slot.
    always_comb begin
        w_line_next = r_line;
        for (int i = 0; i < c_k; i++) begin
            if (r_slot_cnt == c_slot_w'(i)) begin
                w_line_next[i*c_word_w +: c_word_w] = in_data;
            end
        end
    end

    assign w_rd_nxt = w_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;

    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_count + 1'b1;
            2'b01:   w_cnt_nxt = r_count - 1'b1;
            default: w_cnt_nxt = r_count;
        endcase
    end

    // When the pushed entry becomes the head in the same cycle, the memory
    // does not hold it yet, so the output register takes it directly.
    assign w_head_bypass = w_push && (r_wr_ptr == w_rd_nxt);

    // ------------------------------------------------------------------
    // Line assembly and node line counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot_cnt <= '0;
            r_line_cnt <= 11'd0;
            r_lines_m1 <= 11'd0;
        end else begin
            if (w_latch) begin
                r_lines_m1 <= num_of_line_per_node_minusone;
            end
            if (w_in_hs) begin
                r_slot_cnt <= w_slot_last ? '0 : (r_slot_cnt + 1'b1);
            end
            if (w_push) begin
                r_line_cnt <= w_push_last ? 11'd0 : (r_line_cnt + 11'd1);
            end
        end
    end

    // Partial line contents need no reset: slot_cnt decides what is valid.
    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            r_line <= w_line_next;
        end
    end

    // ------------------------------------------------------------------
    // Line FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wr_ptr] <= w_line_next;
            r_last_mem[r_wr_ptr] <= w_push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_cnt_nxt;
            r_out_vld  <= (w_cnt_nxt != '0);
            r_out_data <= w_head_bypass ? w_line_next  : r_data_mem[w_rd_nxt];
            r_out_last <= w_head_bypass ? w_push_last  : r_last_mem[w_rd_nxt];
        end
    end

    assign out_data = r_out_data;
    assign out_vld  = r_out_vld;
    assign out_last = r_out_last;

    // ------------------------------------------------------------------
    // Exponent tagging
    // ------------------------------------------------------------------
`ifdef RESULT_PACKER_MAXEXP_EN
    logic [7:0] r_exp_latch;
    logic [7:0] r_exp_mem [FIFO_DEPTH];
    logic [7:0] r_out_exp;
    logic [7:0] w_exp_tag;

    // A strobe coinciding with the push is already part of that line's tag.
    assign w_exp_tag = max_exponent_vld ? max_exponent : r_exp_latch;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exp_latch <= 8'd0;
        end else if (w_push && w_push_last) begin
            r_exp_latch <= 8'd0;
        end else if (max_exponent_vld) begin
            r_exp_latch <= max_exponent;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_exp_mem[r_wr_ptr] <= w_exp_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_exp <= 8'd0;
        end else begin
            r_out_exp <= w_head_bypass ? w_exp_tag : r_exp_mem[w_rd_nxt];
        end
    end

    assign out_max_exponent = r_out_exp;
`else
    logic w_unused_exp;
    assign w_unused_exp     = ^{max_exponent, max_exponent_vld};
    assign out_max_exponent = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_small_result_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_small_result_packer
// Description : Directed testbench for small_result_packer with DW=32
//               (K=2 words per line) and FIFO_DEPTH=4. Expected lines,
//               last flags and exponent tags are written out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_small_result_packer;

    localparam int DW         = 32;
    localparam int FIFO_DEPTH = 4;

`ifdef RESULT_PACKER_MAXEXP_EN
    localparam logic [7:0] c_exp_a = 8'h85;
    localparam logic [7:0] c_exp_b = 8'h12;
`else
    localparam logic [7:0] c_exp_a = 8'h00;
    localparam logic [7:0] c_exp_b = 8'h00;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [127:0]   in_data = '0;
    logic           in_vld = 1'b0;
    logic           in_ready;
    logic [10:0]    num_of_line_per_node_minusone = 11'd0;
    logic [7:0]     max_exponent = 8'd0;
    logic           max_exponent_vld = 1'b0;
    logic [255:0]   out_data;
    logic           out_vld;
    logic           out_ready = 1'b0;
    logic           out_last;
    logic [7:0]     out_max_exponent;

    int n_checks = 0;
    int n_errors = 0;

    small_result_packer #(
        .DW         (DW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .in_data                       (in_data),
        .in_vld                        (in_vld),
        .in_ready                      (in_ready),
        .num_of_line_per_node_minusone (num_of_line_per_node_minusone),
        .max_exponent                  (max_exponent),
        .max_exponent_vld              (max_exponent_vld),
        .out_data                      (out_data),
        .out_vld                       (out_vld),
        .out_ready                     (out_ready),
        .out_last                      (out_last),
        .out_max_exponent              (out_max_exponent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] wd(input int i);
        return {96'hFACE_0000_1234_5678_9ABC_DEF0, 32'(i)};
    endfunction

    function automatic logic [255:0] ln(input int lo, input int hi);
        return {wd(hi), wd(lo)};
    endfunction

    task automatic do_reset(input int cycles);
        in_vld = 1'b0;
        rst    = 1'b0;
        repeat (cycles) step();
        rst    = 1'b1;
    endtask

    // Offer one word and hold it until it is accepted (bounded wait).
    task automatic send_word(input logic [127:0] w);
        int n;
        n       = 0;
        in_data = w;
        in_vld  = 1'b1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("send_timeout", in_ready, 1'b1);
        step();
        in_vld = 1'b0;
    endtask

    // Check the head line, then pop it.
    task automatic pop_check(input string tag, input logic [255:0] d,
                             input logic l, input logic [7:0] e);
        chk({tag, "_vld"},  out_vld,  1'b1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_last"}, out_last, l);
        if (l) chk({tag, "_exp"}, out_max_exponent, e);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int acc;

        // ---------------- Reset with in_vld held high ----------------
        rst     = 1'b0;
        in_vld  = 1'b1;
        in_data = wd(99);
        repeat (3) step();
        chk("rst_out_vld",  out_vld,  1'b0);
        chk("rst_out_data", out_data, 256'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_exp",  out_max_exponent, 8'd0);
        in_vld = 1'b0;
        rst    = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        step();
        chk("rst_idle_vld", out_vld, 1'b0);

        // ---------------- Pack two words into one line ----------------
        num_of_line_per_node_minusone = 11'd3;
        out_ready = 1'b1;
        send_word(wd(1));
        chk("pack_half_vld", out_vld, 1'b0);
        send_word(wd(2));
        chk("pack_vld",  out_vld,  1'b1);
        chk("pack_data", out_data, ln(1, 2));
        chk("pack_last", out_last, 1'b0);
        step();
        chk("pack_popped", out_vld, 1'b0);
        out_ready = 1'b0;

        // ---------------- Backpressure ----------------
        do_reset(1);
        num_of_line_per_node_minusone = 11'd3;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_data = wd(i);
            in_vld  = 1'b1;
            if (in_ready) acc++;
            step();
        end
        chk("bp_accepted", 32'(acc), 32'd9);
        chk("bp_in_ready_full", in_ready, 1'b0);
        chk("bp_head", out_data, ln(0, 1));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_in_ready_after_pop", in_ready, 1'b1);
        step();                         // word 9 completes line {W9,W8}
        in_vld = 1'b0;
        pop_check("bp_l1", ln(2, 3), 1'b0, 8'd0);
        pop_check("bp_l2", ln(4, 5), 1'b0, 8'd0);
        pop_check("bp_l3", ln(6, 7), 1'b1, 8'd0);
        pop_check("bp_l4", ln(8, 9), 1'b0, 8'd0);
        chk("bp_empty", out_vld, 1'b0);

        // ---------------- Node boundary, minusone=1 ----------------
        do_reset(1);
        num_of_line_per_node_minusone = 11'd1;
        send_word(wd(10));
        num_of_line_per_node_minusone = 11'd5;   // mid-node change is ignored
        send_word(wd(11));
        num_of_line_per_node_minusone = 11'd1;
        for (int i = 12; i < 18; i++) send_word(wd(i));
        pop_check("nb_l0", ln(10, 11), 1'b0, 8'd0);
        pop_check("nb_l1", ln(12, 13), 1'b1, 8'd0);
        pop_check("nb_l2", ln(14, 15), 1'b0, 8'd0);
        pop_check("nb_l3", ln(16, 17), 1'b1, 8'd0);
        chk("nb_empty", out_vld, 1'b0);

        // ---------------- Exponent tagging ----------------
        do_reset(1);
        num_of_line_per_node_minusone = 11'd1;
        send_word(wd(20));
        max_exponent     = 8'h85;
        max_exponent_vld = 1'b1;
        step();
        max_exponent_vld = 1'b0;
        max_exponent     = 8'h00;
        for (int i = 21; i < 28; i++) send_word(wd(i));
        pop_check("ex_l0", ln(20, 21), 1'b0, 8'd0);
        pop_check("ex_l1", ln(22, 23), 1'b1, c_exp_a);
        pop_check("ex_l2", ln(24, 25), 1'b0, 8'd0);
        pop_check("ex_l3", ln(26, 27), 1'b1, 8'd0);
        // minusone=0: every line last; strobe with the completing word
        num_of_line_per_node_minusone = 11'd0;
        send_word(wd(30));
        max_exponent     = 8'h12;
        max_exponent_vld = 1'b1;
        send_word(wd(31));
        max_exponent_vld = 1'b0;
        max_exponent     = 8'h00;
        send_word(wd(32));
        send_word(wd(33));
        pop_check("ex_z0", ln(30, 31), 1'b1, c_exp_b);
        pop_check("ex_z1", ln(32, 33), 1'b1, 8'd0);

        // ---------------- Reset mid-operation ----------------
        do_reset(1);
        num_of_line_per_node_minusone = 11'd3;
        for (int i = 40; i < 45; i++) send_word(wd(i));
        chk("mr_queued_vld", out_vld, 1'b1);
        do_reset(1);
        chk("mr_out_vld",  out_vld,  1'b0);
        chk("mr_in_ready", in_ready, 1'b1);
        send_word(wd(50));
        send_word(wd(51));
        pop_check("mr_line", ln(50, 51), 1'b0, 8'd0);
        chk("mr_empty", out_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/small_result_packer.md
SMALL_RESULT_PACKER -- requirements
Module: small_result_packer

Interface
REQ-001 Parameter DW, default 32: result element width; the input word is 4*DW bits; legal values are 8, 16, 32 and 64.
REQ-002 Parameter FIFO_DEPTH, default 4: output line FIFO depth; SHALL be a power of two, at least 2.
REQ-003 Derived constant K = 256/(4*DW): results per output line.
REQ-004 clk  input  1  single clock; all logic updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 in_data  input  4*DW  result word from the multiplier node (its interface_out).
REQ-007 in_vld  input  1  in_data is valid.
REQ-008 in_ready  output  1  packer accepts in_data this cycle.
REQ-009 num_of_line_per_node_minusone  input  11  number of output lines per node, minus 1.
REQ-010 max_exponent  input  8  node maximum exponent.
REQ-011 max_exponent_vld  input  1  one-cycle strobe qualifying max_exponent.
REQ-012 out_data  output  256  packed line at the FIFO head.
REQ-013 out_vld  output  1  out_data is valid.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 out_last  output  1  the head line is the final line of a node.
REQ-016 out_max_exponent  output  8  exponent tag, meaningful only when out_last is high.

Function
REQ-017 An input handshake SHALL occur when in_vld and in_ready are both high.
- The word is written to slot slot_cnt, at bits [(slot_cnt+1)*4*DW-1 : slot_cnt*4*DW] (slot 0 is least significant).
- slot_cnt then increments.
REQ-018 A handshake in slot K-1 SHALL push the assembled line into the FIFO and return slot_cnt to 0.
REQ-019 in_ready SHALL be driven as (slot_cnt != K-1) OR (FIFO not full).
- It is a registered-state function only.
- It has no combinational path from out_ready.
REQ-020 out_vld SHALL be high exactly when the FIFO is not empty.
- out_data, out_last and out_max_exponent come from the head entry.
- Output signals are driven from registers, not combinationally.
REQ-021 A pop SHALL occur on out_vld AND out_ready; a simultaneous push and pop SHALL keep the FIFO count unchanged.
REQ-022 Latency: the line completed in cycle t SHALL appear with out_vld high in cycle t+1 when the FIFO was empty.
REQ-023 Node line counter line_cnt SHALL increment on every push.
- The pushed line is tagged last when line_cnt equals the latched line count.
- line_cnt wraps to 0 after a last line.
REQ-024 num_of_line_per_node_minusone SHALL be latched on the first input handshake while line_cnt==0 and slot_cnt==0; it is ignored otherwise.
REQ-025 A latched value of 0 SHALL tag every line as last.
REQ-026 Lines SHALL be emitted in push order; no line is dropped or duplicated under any in_vld/out_ready pattern.
REQ-027 A partially filled line SHALL be held indefinitely until K words have been accepted; there is no timeout and no padding.

Reset
REQ-028 While rst is low at a clock edge, the following SHALL be cleared to 0:
- slot_cnt, line_cnt and the FIFO pointers/count
- out_vld, out_last and out_max_exponent
- out_data and the latched line count
REQ-029 Reset mid-operation SHALL discard the partial line and all queued lines.
- in_ready is 1 in the first cycle after rst returns high.
- The next accepted word lands in slot 0.

Configuration
REQ-030 Macro RESULT_PACKER_MAXEXP_EN controls exponent tagging.
REQ-031 With RESULT_PACKER_MAXEXP_EN defined:
- max_exponent is latched on each max_exponent_vld; the latch is cleared to 0 after a last line is pushed.
- The latched value is stored with each pushed line.
- out_max_exponent carries the stored value.
- A strobe in the same cycle as the last push is included in that line's tag.
REQ-032 Without the macro:
- No exponent storage is built.
- max_exponent and max_exponent_vld are ignored.
- out_max_exponent is constant 0.

Verification (DW=32, K=2, FIFO_DEPTH=4)
REQ-033 Reset: rst low for 3 cycles with in_vld=1 -> out_vld=0, out_data=0, and in_ready=1 after release.
REQ-034 Pack: minusone=3, out_ready=1, words A then B on consecutive cycles -> next cycle out_vld=1, out_data={B,A}, out_last=0.
REQ-035 Backpressure: out_ready=0, 10 words offered -> 9 accepted and in_ready=0; out_ready=1 for one cycle -> in_ready=1 the next cycle, and lines pop in order.
REQ-036 Node boundary: minusone=1, 8 words -> 4 lines with out_last pattern 0,1,0,1.
REQ-037 Macro on: minusone=1, max_exponent=0x85 strobed during the node -> last line carries out_max_exponent=0x85, and the next node's last line carries 0 if no strobe.
REQ-038 Reset mid-operation: 2 lines queued plus 1 word pending, then rst low 1 cycle -> out_vld=0, and the next 2 words form the line {W1,W0}.
